// File: rtl/pma_region_table_pkg.sv
// Shared types and helpers for the runtime-programmable PMA region table.
package pma_region_table_pkg;

  // Internal storage width; module AddrWidth must not exceed this.
  localparam int unsigned PmaAddrWidth = 64;
  localparam int unsigned PmaAttrWidth = 4;

  typedef struct packed {
    logic lock;
    logic nonidem;
    logic cached;
    logic exec;
  } pma_attr_t;

  typedef struct packed {
    logic [PmaAddrWidth-1:0] base;
    logic [PmaAddrWidth-1:0] len;
    pma_attr_t               attr;
  } pma_rule_t;

  typedef enum logic [1:0] {
    FIELD_BASE = 2'd0,
    FIELD_LEN  = 2'd1,
    FIELD_ATTR = 2'd2,
    FIELD_RSVD = 2'd3
  } pma_field_e;

  // Range check with the end computed one bit wider so a region ending at the
  // top of the address space neither wraps nor needs special casing.
  function automatic logic pma_match(input pma_rule_t rule,
                                     input logic [PmaAddrWidth-1:0] addr);
    logic [PmaAddrWidth:0] end_w;
    end_w = {1'b0, rule.base} + {1'b0, rule.len};
    return (rule.len != '0) && (addr >= rule.base) && ({1'b0, addr} < end_w);
  endfunction

endpackage

// File: rtl/pma_lookup_port.sv
// One lookup channel: priority match over the active table, registered result.
module pma_lookup_port
  import pma_region_table_pkg::*;
#(
  parameter int unsigned NrRules  = 8,
  parameter int unsigned IdxWidth = 3
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  pma_rule_t [NrRules-1:0]   rules_i,
  input  logic                      valid_i,
  input  logic [PmaAddrWidth-1:0]   addr_i,
  output logic                      valid_o,
  output logic                      hit_o,
  output logic [IdxWidth-1:0]       idx_o,
  output logic [2:0]                attr_o
);

  logic                hit_c;
  logic [IdxWidth-1:0] idx_c;
  logic [2:0]          attr_c;
  logic                unused_lock;

  // Lowest-index enabled rule covering the address wins.
  always_comb begin
    hit_c  = 1'b0;
    idx_c  = '0;
    attr_c = '0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      if (!hit_c && pma_match(rules_i[r], addr_i)) begin
        hit_c  = 1'b1;
        idx_c  = IdxWidth'(r);
        attr_c = {rules_i[r].attr.nonidem, rules_i[r].attr.cached, rules_i[r].attr.exec};
      end
    end
  end

  // Lock bits only matter on the config side; fold them away here.
  always_comb begin
    unused_lock = 1'b0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      unused_lock = unused_lock ^ rules_i[r].attr.lock;
    end
  end

  // Result register; fields read as zero when no lookup was issued.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      hit_o   <= 1'b0;
      idx_o   <= '0;
      attr_o  <= '0;
    end else begin
      valid_o <= valid_i;
      hit_o   <= valid_i & hit_c;
      idx_o   <= valid_i ? idx_c : '0;
      attr_o  <= valid_i ? attr_c : '0;
    end
  end

endmodule

// File: rtl/pma_region_table.sv
// Runtime-programmable PMA region table: shadow/active rule pair, config port,
// and NrPorts independent single-cycle lookups against the active table.
module pma_region_table
  import pma_region_table_pkg::*;
#(
  parameter int unsigned NrRules   = 8,
  parameter int unsigned NrPorts   = 2,
  parameter int unsigned AddrWidth = 64,
  parameter logic [NrRules*AddrWidth-1:0]    RstBase = '0,
  parameter logic [NrRules*AddrWidth-1:0]    RstLen  = '0,
  parameter logic [NrRules*PmaAttrWidth-1:0] RstAttr = '0,
  localparam int unsigned IdxWidth = (NrRules > 1) ? $clog2(NrRules) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_req_i,
  input  logic                          cfg_we_i,
  input  logic [IdxWidth-1:0]           cfg_idx_i,
  input  logic [1:0]                    cfg_field_i,
  input  logic [AddrWidth-1:0]          cfg_wdata_i,
  input  logic                          cfg_commit_i,
  output logic                          cfg_rvalid_o,
  output logic [AddrWidth-1:0]          cfg_rdata_o,
  output logic                          cfg_err_o,
  input  logic [NrPorts-1:0]            lk_valid_i,
  input  logic [NrPorts*AddrWidth-1:0]  lk_addr_i,
  output logic [NrPorts-1:0]            lk_valid_o,
  output logic [NrPorts-1:0]            lk_hit_o,
  output logic [NrPorts*IdxWidth-1:0]   lk_idx_o,
  output logic [NrPorts*3-1:0]          lk_attr_o
);

  pma_rule_t [NrRules-1:0] shadow_q;
  pma_rule_t [NrRules-1:0] active_q;
  pma_rule_t [NrRules-1:0] rst_tbl;

  pma_field_e             field_c;
  pma_rule_t              sel_rule_c;
  logic                   idx_ok_c;
  logic                   locked_c;
  logic                   err_c;
  logic                   wr_en_c;
  logic [AddrWidth-1:0]   rdata_c;

  // Unpack the reset parameters into rule form.
  always_comb begin
    rst_tbl = '0;
    for (int unsigned r = 0; r < NrRules; r++) begin
      rst_tbl[r].base = PmaAddrWidth'(RstBase[r*AddrWidth +: AddrWidth]);
      rst_tbl[r].len  = PmaAddrWidth'(RstLen[r*AddrWidth +: AddrWidth]);
      rst_tbl[r].attr = pma_attr_t'(RstAttr[r*PmaAttrWidth +: PmaAttrWidth]);
    end
  end

  // Config decode: legality, lock check against the active copy, read mux.
  always_comb begin
    field_c    = pma_field_e'(cfg_field_i);
    idx_ok_c   = (32'(cfg_idx_i) < NrRules);
    sel_rule_c = idx_ok_c ? shadow_q[cfg_idx_i] : '0;
    locked_c   = idx_ok_c && active_q[cfg_idx_i].attr.lock;
    err_c      = !idx_ok_c || (field_c == FIELD_RSVD) || (cfg_we_i && locked_c);
    wr_en_c    = cfg_req_i && cfg_we_i && !err_c;
    rdata_c    = '0;
    if (!cfg_we_i && !err_c) begin
      case (field_c)
        FIELD_BASE: rdata_c = AddrWidth'(sel_rule_c.base);
        FIELD_LEN:  rdata_c = AddrWidth'(sel_rule_c.len);
        FIELD_ATTR: rdata_c = AddrWidth'(sel_rule_c.attr);
        default:    rdata_c = '0;
      endcase
    end
  end

  // Shadow writes and commit; commit samples the pre-write shadow and skips
  // rules whose active lock is set.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shadow_q <= rst_tbl;
      active_q <= rst_tbl;
    end else begin
      if (wr_en_c) begin
        case (field_c)
          FIELD_BASE: shadow_q[cfg_idx_i].base <= PmaAddrWidth'(cfg_wdata_i);
          FIELD_LEN:  shadow_q[cfg_idx_i].len  <= PmaAddrWidth'(cfg_wdata_i);
          FIELD_ATTR: shadow_q[cfg_idx_i].attr <= pma_attr_t'(cfg_wdata_i[PmaAttrWidth-1:0]);
          default:    ;
        endcase
      end
      if (cfg_commit_i) begin
        for (int unsigned r = 0; r < NrRules; r++) begin
          if (!active_q[r].attr.lock) begin
            active_q[r] <= shadow_q[r];
          end
        end
      end
    end
  end

  // Config response register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cfg_rvalid_o <= 1'b0;
      cfg_rdata_o  <= '0;
      cfg_err_o    <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_req_i;
      cfg_rdata_o  <= cfg_req_i ? rdata_c : '0;
      cfg_err_o    <= cfg_req_i & err_c;
    end
  end

  // Independent lookup channels.
  for (genvar p = 0; p < NrPorts; p++) begin : g_port
    logic [PmaAddrWidth-1:0] addr_ext;
    assign addr_ext = PmaAddrWidth'(lk_addr_i[p*AddrWidth +: AddrWidth]);

    pma_lookup_port #(
      .NrRules  (NrRules),
      .IdxWidth (IdxWidth)
    ) u_port (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .rules_i (active_q),
      .valid_i (lk_valid_i[p]),
      .addr_i  (addr_ext),
      .valid_o (lk_valid_o[p]),
      .hit_o   (lk_hit_o[p]),
      .idx_o   (lk_idx_o[p*IdxWidth +: IdxWidth]),
      .attr_o  (lk_attr_o[p*3 +: 3])
    );
  end

endmodule

// File: tb/tb_pma_region_table.sv
// Directed self-checking bench for pma_region_table.
`timescale 1ns/1ps
module tb_pma_region_table;

  localparam int unsigned NR = 8;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 3;

  localparam logic [NR*AW-1:0] RST_BASE = {{(NR-1)*AW{1'b0}}, 64'h0000_0000_8000_0000};
  localparam logic [NR*AW-1:0] RST_LEN  = {{(NR-1)*AW{1'b0}}, 64'h0000_0000_4000_0000};
  localparam logic [NR*4-1:0]  RST_ATTR = {{(NR-1)*4{1'b0}}, 4'b0011};

  localparam logic [1:0] F_BASE = 2'd0;
  localparam logic [1:0] F_LEN  = 2'd1;
  localparam logic [1:0] F_ATTR = 2'd2;
  localparam logic [1:0] F_RSVD = 2'd3;

  logic             clk;
  logic             rst;
  logic             cfg_req;
  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [1:0]       cfg_field;
  logic [AW-1:0]    cfg_wdata;
  logic             cfg_commit;
  logic             cfg_rvalid;
  logic [AW-1:0]    cfg_rdata;
  logic             cfg_err;
  logic [NP-1:0]    lk_valid_in;
  logic [NP*AW-1:0] lk_addr;
  logic [NP-1:0]    lk_valid_out;
  logic [NP-1:0]    lk_hit;
  logic [NP*IW-1:0] lk_idx;
  logic [NP*3-1:0]  lk_attr;

  int checks = 0;
  int errors = 0;

  pma_region_table #(
    .NrRules   (NR),
    .NrPorts   (NP),
    .AddrWidth (AW),
    .RstBase   (RST_BASE),
    .RstLen    (RST_LEN),
    .RstAttr   (RST_ATTR)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_req_i    (cfg_req),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_field_i  (cfg_field),
    .cfg_wdata_i  (cfg_wdata),
    .cfg_commit_i (cfg_commit),
    .cfg_rvalid_o (cfg_rvalid),
    .cfg_rdata_o  (cfg_rdata),
    .cfg_err_o    (cfg_err),
    .lk_valid_i   (lk_valid_in),
    .lk_addr_i    (lk_addr),
    .lk_valid_o   (lk_valid_out),
    .lk_hit_o     (lk_hit),
    .lk_idx_o     (lk_idx),
    .lk_attr_o    (lk_attr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One config access; returns the registered response.
  task automatic cfg_op(input logic we, input logic [IW-1:0] idx, input logic [1:0] field,
                        input logic [AW-1:0] wdata, input logic commit,
                        output logic rv, output logic er, output logic [AW-1:0] rd);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = field;
    cfg_wdata = wdata; cfg_commit = commit;
    step();
    rv = cfg_rvalid; er = cfg_err; rd = cfg_rdata;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_wdata = '0;
  endtask

  task automatic commit_only();
    cfg_commit = 1'b1;
    step();
    cfg_commit = 1'b0;
  endtask

  // Port-0 lookup; result packed as {valid, hit, idx[2:0], attr[2:0]}.
  task automatic lookup0(input logic [AW-1:0] addr, output logic [7:0] r);
    lk_valid_in = 2'b01;
    lk_addr = {{AW{1'b0}}, addr};
    step();
    r = {lk_valid_out[0], lk_hit[0], lk_idx[IW-1:0], lk_attr[2:0]};
    lk_valid_in = '0;
    lk_addr = '0;
  endtask

  task automatic test_reset();
    logic [7:0] r;
    rst = 1'b1;
    step();
    checks++;
    if ({cfg_rvalid, cfg_err, cfg_rdata, lk_valid_out, lk_hit, lk_idx, lk_attr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got rv=%b err=%b rd=%h v=%b h=%b, required all zero",
               cfg_rvalid, cfg_err, cfg_rdata, lk_valid_out, lk_hit);
    end
    step();
    rst = 1'b0;
    lookup0(64'h8000_1000, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd0, 3'b011}) begin
      errors++; $display("FAIL reset_rule0_hit: got %b required %b", r, {1'b1, 1'b1, 3'd0, 3'b011});
    end
    lookup0(64'hC000_0000, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_rule0_end_excl: got %b required %b", r, 8'b1000_0000);
    end
    lookup0(64'hBFFF_FFFF, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd0, 3'b011}) begin
      errors++; $display("FAIL reset_rule0_last: got %b required %b", r, {1'b1, 1'b1, 3'd0, 3'b011});
    end
    lookup0(64'h7FFF_FFFF, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_rule0_below: got %b required %b", r, 8'b1000_0000);
    end
    step();
    checks++;
    if ({lk_valid_out, lk_hit, lk_idx, lk_attr} !== '0) begin
      errors++; $display("FAIL idle_lookup_zero: got v=%b h=%b idx=%h attr=%h required 0",
                         lk_valid_out, lk_hit, lk_idx, lk_attr);
    end
  endtask

  task automatic test_shadow_commit();
    logic rv, er;
    logic [AW-1:0] rd;
    logic [7:0] r;
    cfg_op(1'b1, 3'd1, F_BASE, 64'h1_0000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd1, F_LEN,  64'h1_0000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd1, F_ATTR, 64'h1,      1'b0, rv, er, rd);
    checks++;
    if ({rv, er} !== 2'b10) begin
      errors++; $display("FAIL write_resp: got rv=%b err=%b required rv=1 err=0", rv, er);
    end
    cfg_op(1'b0, 3'd1, F_BASE, '0, 1'b0, rv, er, rd);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b0, 64'h1_0000}) begin
      errors++; $display("FAIL shadow_readback: got rv=%b err=%b rd=%h required 1 0 10000", rv, er, rd);
    end
    lookup0(64'h1_0040, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL precommit_miss: got %b required %b", r, 8'b1000_0000);
    end
    cfg_commit = 1'b1;
    lk_valid_in = 2'b01;
    lk_addr = {{AW{1'b0}}, 64'h1_0040};
    step();
    r = {lk_valid_out[0], lk_hit[0], lk_idx[IW-1:0], lk_attr[2:0]};
    cfg_commit = 1'b0; lk_valid_in = '0; lk_addr = '0;
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL commit_cycle_old_table: got %b required %b", r, 8'b1000_0000);
    end
    lookup0(64'h1_0040, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd1, 3'b001}) begin
      errors++; $display("FAIL postcommit_hit: got %b required %b", r, {1'b1, 1'b1, 3'd1, 3'b001});
    end
  endtask

  task automatic test_priority_top();
    logic rv, er;
    logic [AW-1:0] rd;
    logic [7:0] r;
    cfg_op(1'b1, 3'd2, F_BASE, 64'hFFFF_FFFF_FFFF_F000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd2, F_LEN,  64'h1000,                1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd2, F_ATTR, 64'h4,                   1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd3, F_BASE, 64'hFFFF_FFFF_FFFF_F000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd3, F_LEN,  64'h1000,                1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd3, F_ATTR, 64'h2,                   1'b0, rv, er, rd);
    commit_only();
    lookup0(64'hFFFF_FFFF_FFFF_FFFF, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd2, 3'b100}) begin
      errors++; $display("FAIL top_of_space_prio: got %b required %b", r, {1'b1, 1'b1, 3'd2, 3'b100});
    end
    lookup0(64'hFFFF_FFFF_FFFF_F000, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd2, 3'b100}) begin
      errors++; $display("FAIL top_region_base: got %b required %b", r, {1'b1, 1'b1, 3'd2, 3'b100});
    end
    lookup0(64'hFFFF_FFFF_FFFF_EFFF, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL top_region_below: got %b required %b", r, 8'b1000_0000);
    end
    lookup0(64'h0, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL no_wrap_at_zero: got %b required %b", r, 8'b1000_0000);
    end
  endtask

  task automatic test_lock();
    logic rv, er;
    logic [AW-1:0] rd;
    logic [7:0] r;
    cfg_op(1'b1, 3'd4, F_BASE, 64'h2000_0000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd4, F_LEN,  64'h1000,      1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd4, F_ATTR, 64'h9,         1'b0, rv, er, rd);
    // Commit locks rule4 while the same-cycle write still lands in shadow.
    cfg_op(1'b1, 3'd4, F_BASE, 64'h3000_0000, 1'b1, rv, er, rd);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL write_before_lock: got err=%b required 0", er);
    end
    commit_only();
    lookup0(64'h2000_0000, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd4, 3'b001}) begin
      errors++; $display("FAIL locked_keeps_active: got %b required %b", r, {1'b1, 1'b1, 3'd4, 3'b001});
    end
    lookup0(64'h3000_0000, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL locked_not_recommitted: got %b required %b", r, 8'b1000_0000);
    end
    cfg_op(1'b1, 3'd4, F_BASE, 64'h4000_0000, 1'b0, rv, er, rd);
    checks++;
    if ({rv, er} !== 2'b11) begin
      errors++; $display("FAIL locked_write_err: got rv=%b err=%b required 1 1", rv, er);
    end
    cfg_op(1'b0, 3'd4, F_BASE, '0, 1'b0, rv, er, rd);
    checks++;
    if ({er, rd} !== {1'b0, 64'h3000_0000}) begin
      errors++; $display("FAIL locked_base_unchanged: got err=%b rd=%h required 0 30000000", er, rd);
    end
    cfg_op(1'b1, 3'd4, F_ATTR, 64'h0, 1'b0, rv, er, rd);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL lock_sticky: got err=%b required 1", er);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    lookup0(64'h2000_0000, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL reset_clears_rule4: got %b required %b", r, 8'b1000_0000);
    end
    cfg_op(1'b0, 3'd4, F_ATTR, '0, 1'b0, rv, er, rd);
    checks++;
    if ({er, rd} !== {1'b0, 64'h0}) begin
      errors++; $display("FAIL reset_attr4: got err=%b rd=%h required 0 0", er, rd);
    end
    cfg_op(1'b1, 3'd4, F_BASE, 64'h5000, 1'b0, rv, er, rd);
    checks++;
    if (er !== 1'b0) begin
      errors++; $display("FAIL unlock_after_reset: got err=%b required 0", er);
    end
    cfg_op(1'b0, 3'd1, F_BASE, '0, 1'b0, rv, er, rd);
    checks++;
    if (rd !== 64'h0) begin
      errors++; $display("FAIL reset_shadow_rule1: got rd=%h required 0", rd);
    end
  endtask

  task automatic test_cfg_corner();
    logic rv, er;
    logic [AW-1:0] rd;
    logic [7:0] r;
    cfg_op(1'b0, 3'd0, F_RSVD, '0, 1'b0, rv, er, rd);
    checks++;
    if ({rv, er, rd} !== {1'b1, 1'b1, 64'h0}) begin
      errors++; $display("FAIL field3_read: got rv=%b err=%b rd=%h required 1 1 0", rv, er, rd);
    end
    cfg_op(1'b1, 3'd0, F_RSVD, 64'hFFFF, 1'b0, rv, er, rd);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL field3_write: got err=%b required 1", er);
    end
    step();
    checks++;
    if ({cfg_rvalid, cfg_err} !== 2'b00) begin
      errors++; $display("FAIL resp_one_cycle: got rv=%b err=%b required 0 0", cfg_rvalid, cfg_err);
    end
    cfg_op(1'b1, 3'd5, F_BASE, 64'h5000_0000, 1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd5, F_LEN,  64'h100,       1'b0, rv, er, rd);
    cfg_op(1'b1, 3'd5, F_ATTR, 64'h1,         1'b0, rv, er, rd);
    commit_only();
    cfg_op(1'b1, 3'd5, F_BASE, 64'h6000_0000, 1'b1, rv, er, rd);
    lookup0(64'h5000_0000, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd5, 3'b001}) begin
      errors++; $display("FAIL wr_commit_old_value: got %b required %b", r, {1'b1, 1'b1, 3'd5, 3'b001});
    end
    lookup0(64'h6000_0000, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL wr_commit_new_pending: got %b required %b", r, 8'b1000_0000);
    end
    commit_only();
    lookup0(64'h6000_0000, r);
    checks++;
    if (r !== {1'b1, 1'b1, 3'd5, 3'b001}) begin
      errors++; $display("FAIL second_commit_applies: got %b required %b", r, {1'b1, 1'b1, 3'd5, 3'b001});
    end
    lookup0(64'h5000_0000, r);
    checks++;
    if (r !== 8'b1000_0000) begin
      errors++; $display("FAIL old_region_gone: got %b required %b", r, 8'b1000_0000);
    end
  endtask

  task automatic test_two_port();
    logic [7:0] r0, r1;
    lk_valid_in = 2'b11;
    lk_addr = {64'h0, 64'h8000_0000};
    step();
    r0 = {lk_valid_out[0], lk_hit[0], lk_idx[2:0], lk_attr[2:0]};
    r1 = {lk_valid_out[1], lk_hit[1], lk_idx[5:3], lk_attr[5:3]};
    checks++;
    if ({r0, r1} !== {1'b1, 1'b1, 3'd0, 3'b011, 8'b1000_0000}) begin
      errors++; $display("FAIL two_port_independent: got p0=%b p1=%b required p0=11000011 p1=10000000", r0, r1);
    end
    lk_addr = {64'h6000_0010, 64'h6000_0010};
    step();
    r0 = {lk_valid_out[0], lk_hit[0], lk_idx[2:0], lk_attr[2:0]};
    r1 = {lk_valid_out[1], lk_hit[1], lk_idx[5:3], lk_attr[5:3]};
    checks++;
    if ({r0, r1} !== {2{1'b1, 1'b1, 3'd5, 3'b001}}) begin
      errors++; $display("FAIL two_port_same_addr: got p0=%b p1=%b required 11101001 each", r0, r1);
    end
    lk_valid_in = 2'b10;
    lk_addr = {64'h8000_0000, 64'h8000_0000};
    step();
    r0 = {lk_valid_out[0], lk_hit[0], lk_idx[2:0], lk_attr[2:0]};
    r1 = {lk_valid_out[1], lk_hit[1], lk_idx[5:3], lk_attr[5:3]};
    checks++;
    if ({r0, r1} !== {8'b0000_0000, 1'b1, 1'b1, 3'd0, 3'b011}) begin
      errors++; $display("FAIL port1_only: got p0=%b p1=%b required p0=00000000 p1=11000011", r0, r1);
    end
    lk_valid_in = 2'b11;
    cfg_req = 1'b1;
    rst = 1'b1;
    step();
    checks++;
    if ({lk_valid_out, lk_hit, lk_idx, lk_attr, cfg_rvalid} !== '0) begin
      errors++; $display("FAIL reset_drops_inflight: got v=%b h=%b rv=%b required 0", lk_valid_out, lk_hit, cfg_rvalid);
    end
    rst = 1'b0;
    cfg_req = 1'b0;
    lk_valid_in = '0;
    lk_addr = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cfg_req = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_field = '0;
    cfg_wdata = '0; cfg_commit = 1'b0; lk_valid_in = '0; lk_addr = '0;
    test_reset();
    test_shadow_commit();
    test_priority_top();
    test_lock();
    test_cfg_corner();
    test_two_port();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pma_region_table.md
Name: pma_region_table

Overview:
- Runtime-programmable successor to the static build-time region rules (execute, cached, non-idempotent).
- Holds NrRules address regions, each with an attribute set, in a shadow/active register pair.
- Answers NrPorts independent address lookups with a registered, 1-cycle latency.
- Sits beside the PMP check, feeding the fetch and LSU paths; programmed by the CSR/debug side via a simple request/response port.

Parameters:
- NrRules, 8, number of region entries (1..16).
- NrPorts, 2, number of independent lookup channels.
- AddrWidth, 64, width of lookup addresses and of base/length fields.
- RstBase, all zero, packed NrRules x AddrWidth reset bases.
- RstLen, all zero, packed NrRules x AddrWidth reset lengths; length 0 = rule disabled.
- RstAttr, all zero, packed NrRules x 4 reset attributes {lock, nonidem, cached, exec}.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- cfg_req_i  in  1  config access request
- cfg_we_i  in  1  1 = write, 0 = read
- cfg_idx_i  in  $clog2(NrRules)  rule index
- cfg_field_i  in  2  0 = base, 1 = length, 2 = attr, 3 = reserved
- cfg_wdata_i  in  AddrWidth  write data (attr uses bits [3:0])
- cfg_commit_i  in  1  copy shadow table to active table
- cfg_rvalid_o  out  1  response valid, one cycle after req
- cfg_rdata_o  out  AddrWidth  read data (shadow table)
- cfg_err_o  out  1  response error flag
- lk_valid_i  in  NrPorts  lookup request per port
- lk_addr_i  in  NrPorts x AddrWidth  lookup address
- lk_valid_o  out  NrPorts  result valid
- lk_hit_o  out  NrPorts  some enabled rule matched
- lk_idx_o  out  NrPorts x $clog2(NrRules)  winning rule index
- lk_attr_o  out  NrPorts x 3  {nonidem, cached, exec} of winning rule

Behaviour:
- Reset (rst_i high at a clock edge): shadow and active tables load RstBase/RstLen/RstAttr. All outputs are 0 the following cycle. Any in-flight lookup or config response is dropped.
- Config port is always accepted, one request per cycle, with the response registered one cycle later.
- Read returns the shadow field, zero-extended (attr in [3:0]). Field 3 returns 0 with cfg_err_o=1.
- A write lands in the shadow table at the clock edge.
- A write to any field of a rule whose active lock bit is 1 is ignored, with cfg_err_o=1. Field-3 writes are ignored, with cfg_err_o=1.
- Lock is sticky: it clears only on reset. A write of attr with lock=0 to a locked rule is still rejected.
- Commit: on a cycle with cfg_commit_i=1, active takes shadow for every unlocked rule; locked rules keep their active value.
- If a write and a commit occur in the same cycle, the commit copies the pre-write shadow; the write appears at the next commit.
- Lookup matching: a rule matches when len!=0 and base <= addr < base+len.
  - The end is computed in AddrWidth+1 bits, so a region ending exactly at 2^AddrWidth is valid and does not wrap.
- The lowest-index matching rule wins. If nothing matches: hit=0, idx=0, attr=000.
- Lookup latency is exactly 1 cycle with no backpressure: lk_valid_o[p] is the registered lk_valid_i[p]. When lk_valid_i[p]=0, the result fields hold 0.
- A lookup uses the active table as it stood before the current edge, so a lookup issued in the commit cycle sees the old table.
- Ports are independent; identical addresses on all ports give identical results.

Decomposition:
- A shared package carries:
  - pma_attr_t (lock, nonidem, cached, exec);
  - pma_rule_t (base, len, attr);
  - the field encodings FIELD_BASE/LEN/ATTR;
  - a function pma_match(rule, addr) doing the widened-range compare.
- One sub-module, pma_lookup_port, holds one port's combinational priority match plus its output register. It is instantiated NrPorts times by generate.

Test Plan:
- Reset default: RstBase[0]=0x8000_0000, RstLen[0]=0x4000_0000, RstAttr[0]=0b0011; lookup 0x8000_1000 → next cycle hit=1, idx=0, attr=011; lookup 0xC000_0000 → hit=0.
- Shadow/commit timing: write rule1 base=0x1_0000, len=0x1_0000, attr=0001, then lookup 0x1_0040 → hit=0. Assert commit together with a lookup → hit=0. Lookup one cycle later → hit=1, idx=1.
- Priority plus top-of-space: rule2 = {base 0xFFFF_FFFF_FFFF_F000, len 0x1000, attr 100} and rule3 covering the same range with attr 010, both committed; lookup 0xFFFF_FFFF_FFFF_FFFF → idx=2, attr=100; lookup 0 → no hit from rule2.
- Lock: set rule4 attr=1001 and commit; write rule4 base → cfg_err_o=1, base read unchanged; commit leaves rule4 active; rst_i clears the lock and restores the reset value.
- Config corner cases: a read of field 3 → rdata=0, err=1. A write and commit in the same cycle → the active table gets the old value, and a second commit applies the new one.
- Two-port concurrency: port0=0x8000_0000 and port1=0x0 in the same cycle give independent correct results. Assert rst_i while lk_valid_i=11 → lk_valid_o=00 the next cycle.
